stream_broadcaster: RTL and testbench

- Splits one valid/ready input stream into two independent valid/ready output streams.
- Each accepted input word is divided into two fields, one per output.
- Each output branch has its own buffer, so the branches drain independently.
- The input handshake completes only when both branches can take the word.
- Used wherever one producer feeds two consumers that may stall at different times.

---
 rtl/stream_pkg.sv | 19 +
 rtl/stream_slice.sv | 95 +++++++++
 rtl/stream_broadcaster.sv | 80 ++++++++
 tb/tb_stream_broadcaster.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/stream_pkg.sv
// Shared definitions for the stream broadcaster: buffering-mode names, slice states
// and the mode-to-buffer-depth helper.
package stream_pkg;

  localparam string BURST_YES = "yes";
  localparam string BURST_NO  = "no";

  typedef enum logic [1:0] {
    SL_EMPTY = 2'd0,
    SL_MAIN  = 2'd1,
    SL_BOTH  = 2'd2
  } sliceState_t;

  // "yes" needs a main register plus a skid register; anything else is one register.
  function automatic int bufDepth(input string mode);
    return (mode == BURST_YES) ? 2 : 1;
  endfunction

endpackage

// File: rtl/stream_slice.sv
// One branch buffer of the broadcaster: main register driving the output plus an
// optional skid register, with a registered upstream ready flag.
//
// state    | meaning
// ---------+-----------------------------------------------
// SL_EMPTY | nothing buffered, output invalid
// SL_MAIN  | one word in the main register, output valid
// SL_BOTH  | main and skid full, upstream not ready (skid mode only)
module stream_slice
  import stream_pkg::*;
#(
  parameter int    WIDTH = 8,
  parameter string BURST = BURST_YES
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             push,
  output logic             upReady,
  input  logic [WIDTH-1:0] upData,
  output logic             dnValid,
  input  logic             dnReady,
  output logic [WIDTH-1:0] dnData
);

  localparam int DEPTH  = bufDepth(BURST);
  localparam bit SKIDEN = (DEPTH > 1);

  sliceState_t      state;
  sliceState_t      stateNext;
  logic [WIDTH-1:0] mainReg;
  logic [WIDTH-1:0] mainNext;
  logic [WIDTH-1:0] skidReg;
  logic [WIDTH-1:0] skidNext;
  logic             readyReg;
  logic             readyNext;
  logic             accept;
  logic             pop;

  assign dnValid = (state != SL_EMPTY);
  assign dnData  = mainReg;
  assign upReady = readyReg;
  assign accept  = push && readyReg;
  assign pop     = dnValid && dnReady;

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state    <= SL_EMPTY;
      mainReg  <= '0;
      skidReg  <= '0;
      readyReg <= 1'b0;
    end else begin
      state    <= stateNext;
      mainReg  <= mainNext;
      skidReg  <= skidNext;
      readyReg <= readyNext;
    end
  end

  always_comb begin
    stateNext = state;
    mainNext  = mainReg;
    skidNext  = skidReg;
    unique case (state)
      SL_EMPTY: begin
        if (accept) begin
          stateNext = SL_MAIN;
          mainNext  = upData;
        end
      end
      SL_MAIN: begin
        // Push and pop on the same edge replaces main directly, so no bubble.
        if (accept && pop) begin
          mainNext = upData;
        end else if (accept && SKIDEN) begin
          stateNext = SL_BOTH;
          skidNext  = upData;
        end else if (pop) begin
          stateNext = SL_EMPTY;
        end
      end
      SL_BOTH: begin
        if (pop) begin
          stateNext = SL_MAIN;
          mainNext  = skidReg;
        end
      end
      default: begin
        stateNext = SL_EMPTY;
      end
    endcase
    // Ready is decided from the next state so it is a plain flop, never a path from dnReady.
    readyNext = SKIDEN ? (stateNext != SL_BOTH) : (stateNext == SL_EMPTY);
  end

endmodule

// File: rtl/stream_broadcaster.sv
// Splits one valid/ready stream into two independently buffered branches.
// Define STREAM_BROADCASTER_PROTOCOL_CHECK_EN to compile in simulation-only input checks.
module stream_broadcaster
  import stream_pkg::*;
#(
  parameter int    WIDTH0 = 8,
  parameter int    WIDTH1 = 8,
  parameter string BURST  = BURST_YES
) (
  input  logic                     iCLK,
  input  logic                     iRST,
  input  logic                     iValid_AM,
  output logic                     oReady_AM,
  input  logic [WIDTH0+WIDTH1-1:0] iData_AM,
  output logic                     oValid_BM0,
  input  logic                     iReady_BM0,
  output logic [WIDTH0-1:0]        oData_BM0,
  output logic                     oValid_BM1,
  input  logic                     iReady_BM1,
  output logic [WIDTH1-1:0]        oData_BM1
);

  logic ready0;
  logic ready1;
  logic accept;

  // Both branches must have room, so a word is never split across two edges.
  assign oReady_AM = ready0 && ready1;
  assign accept    = iValid_AM && oReady_AM;

  stream_slice #(
    .WIDTH(WIDTH0),
    .BURST(BURST)
  ) slice0 (
    .iCLK    (iCLK),
    .iRST    (iRST),
    .push    (accept),
    .upReady (ready0),
    .upData  (iData_AM[WIDTH0-1:0]),
    .dnValid (oValid_BM0),
    .dnReady (iReady_BM0),
    .dnData  (oData_BM0)
  );

  stream_slice #(
    .WIDTH(WIDTH1),
    .BURST(BURST)
  ) slice1 (
    .iCLK    (iCLK),
    .iRST    (iRST),
    .push    (accept),
    .upReady (ready1),
    .upData  (iData_AM[WIDTH0+WIDTH1-1:WIDTH0]),
    .dnValid (oValid_BM1),
    .dnReady (iReady_BM1),
    .dnData  (oData_BM1)
  );

`ifdef STREAM_BROADCASTER_PROTOCOL_CHECK_EN
  logic                     chkPending;
  logic [WIDTH0+WIDTH1-1:0] chkData;

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      chkPending <= 1'b0;
      chkData    <= '0;
    end else begin
      if (chkPending && !iValid_AM)
        $error("stream_broadcaster: iValid_AM dropped before the word was accepted");
      if (chkPending && iValid_AM && (iData_AM != chkData))
        $error("stream_broadcaster: iData_AM changed while stalled");
      if (accept && !(ready0 && ready1))
        $error("stream_broadcaster: push into a full branch");
      chkPending <= iValid_AM && !oReady_AM;
      chkData    <= iData_AM;
    end
  end
`endif

endmodule

// File: tb/tb_stream_broadcaster.sv
// Scoreboard bench: two DUTs (skid and single-register modes) with 4-bit fields;
// expected branch words are queued at stimulus time and popped by a negedge monitor.
module tb_stream_broadcaster;

  logic            clk;
  logic [1:0]      rst;
  logic [1:0]      valid;
  logic [1:0]      rdy0;
  logic [1:0]      rdy1;
  logic [1:0]      oRdy;
  logic [1:0]      ov0;
  logic [1:0]      ov1;
  logic [1:0][7:0] din;
  logic [1:0][3:0] od0;
  logic [1:0][3:0] od1;

  logic [3:0] qY0[$];
  logic [3:0] qY1[$];
  logic [3:0] qN0[$];
  logic [3:0] qN1[$];

  int total = 0;
  int bad   = 0;

  stream_broadcaster #(.WIDTH0(4), .WIDTH1(4), .BURST("yes")) dutY (
    .iCLK(clk), .iRST(rst[0]), .iValid_AM(valid[0]), .oReady_AM(oRdy[0]), .iData_AM(din[0]),
    .oValid_BM0(ov0[0]), .iReady_BM0(rdy0[0]), .oData_BM0(od0[0]),
    .oValid_BM1(ov1[0]), .iReady_BM1(rdy1[0]), .oData_BM1(od1[0])
  );

  stream_broadcaster #(.WIDTH0(4), .WIDTH1(4), .BURST("no")) dutN (
    .iCLK(clk), .iRST(rst[1]), .iValid_AM(valid[1]), .oReady_AM(oRdy[1]), .iData_AM(din[1]),
    .oValid_BM0(ov0[1]), .iReady_BM0(rdy0[1]), .oData_BM0(od0[1]),
    .oValid_BM1(ov1[1]), .iReady_BM1(rdy1[1]), .oData_BM1(od1[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expectWord(input int m, input logic [7:0] w);
    if (m == 0) begin
      qY0.push_back(w[3:0]);
      qY1.push_back(w[7:4]);
    end else begin
      qN0.push_back(w[3:0]);
      qN1.push_back(w[7:4]);
    end
  endtask

  task automatic flushQueues(input int m);
    if (m == 0) begin
      qY0.delete();
      qY1.delete();
    end else begin
      qN0.delete();
      qN1.delete();
    end
  endtask

  task automatic popCheck(input int idx, input logic [3:0] act);
    int n;
    logic [3:0] e;
    n = 0;
    e = '0;
    case (idx)
      0: n = qY0.size();
      1: n = qY1.size();
      2: n = qN0.size();
      default: n = qN1.size();
    endcase
    if (n == 0) begin
      total++;
      bad++;
      $display("FAIL pop%0d: got unexpected word %h, want no word (t=%0t)", idx, act, $time);
    end else begin
      case (idx)
        0: e = qY0.pop_front();
        1: e = qY1.pop_front();
        2: e = qN0.pop_front();
        default: e = qN1.pop_front();
      endcase
      chk($sformatf("pop%0d", idx), {4'h0, act}, {4'h0, e});
    end
  endtask

  // A transfer seen at the negedge completes on the following posedge.
  always @(negedge clk) begin
    for (int m = 0; m < 2; m++) begin
      if (!rst[m]) begin
        if (ov0[m] && rdy0[m]) popCheck(m * 2, od0[m]);
        if (ov1[m] && rdy1[m]) popCheck(m * 2 + 1, od1[m]);
      end
    end
  end

  task automatic case0(input int m);
    rdy0[m] = 1'b0; rdy1[m] = 1'b0;
    valid[m] = 1'b1; din[m] = 8'hAB; expectWord(m, 8'hAB);
    tick();
    chk("c0 v0", ov0[m], 1); chk("c0 d0", od0[m], 8'hB);
    chk("c0 v1", ov1[m], 1); chk("c0 d1", od1[m], 8'hA);
    chk("c0 rdy", oRdy[m], (m == 0) ? 1 : 0);
    din[m] = 8'h34; rdy0[m] = 1'b1;
    if (m == 0) expectWord(m, 8'h34);
    tick();
    if (m == 0) begin
      chk("c0b d0", od0[m], 8'h4);
    end else begin
      chk("c0b v0", ov0[m], 0);
    end
    chk("c0b v1", ov1[m], 1); chk("c0b d1", od1[m], 8'hA);
    chk("c0b rdy", oRdy[m], 0);
    valid[m] = 1'b0; rdy0[m] = 1'b0; rdy1[m] = 1'b1;
    tick();
    if (m == 0) begin
      chk("c0c v1", ov1[m], 1); chk("c0c d1", od1[m], 8'h3);
    end else begin
      chk("c0c v1", ov1[m], 0);
    end
    chk("c0c rdy", oRdy[m], 1);
    rdy0[m] = 1'b1; rdy1[m] = 1'b1;
    tick();
    chk("c0d v0", ov0[m], 0); chk("c0d v1", ov1[m], 0); chk("c0d rdy", oRdy[m], 1);
    rdy0[m] = 1'b0; rdy1[m] = 1'b0;
  endtask

  task automatic case1(input int m);
    valid[m] = 1'b1; din[m] = 8'h78; expectWord(m, 8'h78);
    tick();
    valid[m] = 1'b0;
    chk("c1 rdy", oRdy[m], (m == 0) ? 1 : 0);
    rdy0[m] = 1'b1;
    repeat (3) tick();
    chk("c1b v0", ov0[m], 0); chk("c1b v1", ov1[m], 1); chk("c1b d1", od1[m], 8'h7);
    chk("c1b rdy", oRdy[m], (m == 0) ? 1 : 0);
    rdy1[m] = 1'b1;
    tick();
    chk("c1c v1", ov1[m], 0); chk("c1c rdy", oRdy[m], 1);
    rdy0[m] = 1'b0; rdy1[m] = 1'b0;
  endtask

  task automatic streamY();
    logic [3:0] n;
    rdy0[0] = 1'b1; rdy1[0] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      n = 4'(i);
      valid[0] = 1'b1; din[0] = {n, n}; expectWord(0, {n, n});
      tick();
      chk("st rdy", oRdy[0], 1); chk("st v0", ov0[0], 1); chk("st v1", ov1[0], 1);
      chk("st d0", od0[0], {4'h0, n}); chk("st d1", od1[0], {4'h0, n});
    end
    valid[0] = 1'b0;
    repeat (2) tick();
    chk("st idle v0", ov0[0], 0);
    rdy0[0] = 1'b0; rdy1[0] = 1'b0;
  endtask

  task automatic midReset(input int m);
    rdy0[m] = 1'b0; rdy1[m] = 1'b0;
    valid[m] = 1'b1; din[m] = 8'h12; expectWord(m, 8'h12);
    tick();
    if (m == 0) begin
      din[m] = 8'h34; expectWord(m, 8'h34);
      tick();
    end
    valid[m] = 1'b0;
    chk("rs full rdy", oRdy[m], 0);
    rst[m] = 1'b1; flushQueues(m);
    tick();
    chk("rs v0", ov0[m], 0); chk("rs v1", ov1[m], 0);
    chk("rs d0", od0[m], 0); chk("rs rdy", oRdy[m], 0);
    rst[m] = 1'b0;
    tick();
    chk("rs rel rdy", oRdy[m], 1);
    rdy0[m] = 1'b1; rdy1[m] = 1'b1;
    repeat (3) tick();
    chk("rs stale v0", ov0[m], 0); chk("rs stale v1", ov1[m], 0);
    rdy0[m] = 1'b0; rdy1[m] = 1'b0;
  endtask

  initial begin
    #100000;
    bad++;
    $display("FAIL watchdog: got timeout, want completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 2'b11; valid = '0; rdy0 = '0; rdy1 = '0; din = '0;
    repeat (2) tick();
    for (int m = 0; m < 2; m++) begin
      chk("rst rdy", oRdy[m], 0); chk("rst v0", ov0[m], 0); chk("rst v1", ov1[m], 0);
      chk("rst d0", od0[m], 0); chk("rst d1", od1[m], 0);
    end
    rst = 2'b00;
    tick();
    for (int m = 0; m < 2; m++) begin
      chk("rel rdy", oRdy[m], 1); chk("rel v0", ov0[m], 0); chk("rel v1", ov1[m], 0);
    end

    case0(0);
    case1(0);
    streamY();
    midReset(0);

    case0(1);
    case1(1);
    midReset(1);

    tick();
    chk("qY0 left", 8'(qY0.size()), 0);
    chk("qY1 left", 8'(qY1.size()), 0);
    chk("qN0 left", 8'(qN0.size()), 0);
    chk("qN1 left", 8'(qN1.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
